cmd_queue_sched: RTL and testbench
==================================

Name: cmd_queue_sched

Overview:
- Command scheduler between the UART wrapper and the command processor.
- Buffers up to DEPTH 16-bit UART commands in a circular queue and clears the UART ready flag as soon as each command is captured, so the host can stream commands.
- Presents commands one at a time to the command processor through a cmd/cmd_rdy/clr_cmd_rdy handshake.
- Flushes all pending commands on a bump event or on a host flush command.

Parameters:
DEPTH, 4, queue entries; must be a power of 2 and at least 2.
FLUSH_CMD, 16'h0000, UART command value that flushes the queue; it is never enqueued.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous and active-high
uart_cmd  input  16  command from the UART wrapper
uart_rdy  input  1  UART wrapper has a command ready
uart_clr  output  1  one-cycle pulse that clears the UART wrapper's ready flag
bmp_flush  input  1  bump-event flush request, level-sampled each cycle
cmd  output  16  head-of-queue command to the command processor
cmd_rdy  output  1  head entry valid
clr_cmd_rdy  input  1  command processor consumed the head entry (pop)
q_cnt  output  $clog2(DEPTH+1)  occupied entries, 0..DEPTH
full  output  1  q_cnt == DEPTH
overflow  output  1  sticky: at least one command was dropped

Behaviour:
- Reset (rst=1 at a clk edge):
  - read pointer, write pointer and q_cnt cleared to 0
  - overflow=0, uart_clr=0, intake FSM set to TAKE
  - queue memory contents are don't-care
- Priority at each edge: rst > flush > push/pop.
- Intake FSM, 2 states:
  - TAKE: when uart_rdy=1, capture uart_cmd on this edge; go to RELEASE; assert uart_clr (registered) for exactly the next cycle.
  - RELEASE: wait for uart_rdy=0, then return to TAKE. This prevents double capture if the wrapper drops ready late.
- Capture classification, mutually exclusive:
  - (a) uart_cmd == FLUSH_CMD -> flush.
  - (b) not full, or a pop in the same cycle -> push to mem[wr_ptr], wr_ptr++.
  - (c) full with no pop -> drop the command and set overflow=1. uart_clr is still pulsed.
- Output side:
  - cmd = mem[rd_ptr] (combinational read).
  - cmd_rdy = (q_cnt != 0).
  - A command pushed into an empty queue gives cmd_rdy=1 in the cycle after the capture edge (1-cycle latency).
- Pop:
  - clr_cmd_rdy=1 with cmd_rdy=1 -> rd_ptr++ at the edge.
  - clr_cmd_rdy with an empty queue is ignored; no pointer movement or underflow.
  - The consumer pulses clr_cmd_rdy for one cycle per command; a held level pops once per cycle.
- Simultaneous push and pop: q_cnt unchanged, both pointers advance.
  - At full, the pop frees the slot, so the push succeeds with no overflow.
  - In an empty queue, the pop is ignored and the push still occurs.
- Flush (bmp_flush=1, or a FLUSH_CMD capture):
  - rd_ptr=wr_ptr=0, q_cnt=0, overflow cleared.
  - Any simultaneous push or pop that cycle is discarded.
  - cmd_rdy=0 in the next cycle.
  - Intake FSM still moves TAKE->RELEASE normally for a FLUSH_CMD capture.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. q_cnt is tracked separately so full and empty are unambiguous.
- full = (q_cnt == DEPTH); empty is implied by !cmd_rdy.
- rst asserted mid-handshake: uart_clr is forced 0 on the next cycle; any pending command is lost.
- All outputs except cmd and cmd_rdy are registered; cmd and cmd_rdy are derived from registers only, with no input-to-output combinational path.

Test Plan:
- Single command: after reset, send uart_cmd=16'h0003, uart_rdy for 1 cycle -> uart_clr high exactly 1 cycle later; cmd_rdy=1 with cmd=16'h0003 on the cycle after capture; q_cnt=1. Pulse clr_cmd_rdy -> q_cnt=0, cmd_rdy=0.
- Fill and overflow (DEPTH=4): push 16'h0001..16'h0005 with no pops -> full=1 after the 4th; 5th dropped, overflow=1, uart_clr still pulsed. Pop order 0001, 0002, 0003, 0004.
- Push+pop at full: queue full, capture 16'h00AA in the same cycle as clr_cmd_rdy -> q_cnt stays 4, overflow stays 0, 16'h00AA is read last.
- Wrap-around: 10 push/pop pairs with values 16'h0010..16'h0019 -> values returned in order; pointers wrap twice with no corruption.
- Flush: 3 entries queued plus overflow=1, assert bmp_flush 1 cycle -> q_cnt=0, cmd_rdy=0, overflow=0. Repeat using uart_cmd=16'h0000 -> same result and no entry enqueued.
- Held uart_rdy / reset: hold uart_rdy for 5 cycles -> exactly one capture and one uart_clr pulse. Assert rst during RELEASE with 2 entries queued -> next cycle q_cnt=0, uart_clr=0, FSM in TAKE.

Source files
------------

// File: rtl/cmd_queue_sched_if.sv
// ----------------------------------------------------------------------------
// cmd_queue_sched_if
// Groups the UART-side intake handshake, the command-processor handshake and
// the queue status lines of cmd_queue_sched.
//   master : the surroundings (UART wrapper, command processor, bump logic)
//            drive uart_cmd, uart_rdy, bmp_flush and clr_cmd_rdy
//   slave  : the scheduler drives uart_clr, cmd, cmd_rdy, q_cnt, full and
//            overflow
// ----------------------------------------------------------------------------
interface cmd_queue_sched_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   uart_cmd;
  logic          uart_rdy;
  logic          uart_clr;
  logic          bmp_flush;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic [CW-1:0] q_cnt;
  logic          full;
  logic          overflow;

  modport master (
    output uart_cmd, uart_rdy, bmp_flush, clr_cmd_rdy,
    input  uart_clr, cmd, cmd_rdy, q_cnt, full, overflow
  );

  modport slave (
    input  uart_cmd, uart_rdy, bmp_flush, clr_cmd_rdy,
    output uart_clr, cmd, cmd_rdy, q_cnt, full, overflow
  );
endinterface

// File: rtl/cmd_queue_sched.sv
// ----------------------------------------------------------------------------
// cmd_queue_sched
// Circular command queue between the UART wrapper and the command processor.
// Each UART command is captured once per uart_rdy assertion and acknowledged
// with a one-cycle uart_clr pulse, so the host can stream commands. Commands
// leave one at a time through cmd/cmd_rdy/clr_cmd_rdy. A bump event
// (bmp_flush) or a FLUSH_CMD from the host empties the queue.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of cmd_queue_sched_if (intake handshake, output
//              handshake, q_cnt/full/overflow status)
// ----------------------------------------------------------------------------
module cmd_queue_sched #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] FLUSH_CMD = 16'h0000
) (
  input logic              clk,
  input logic              rst,
  cmd_queue_sched_if.slave bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic { TAKE, RELEASE } intake_t;

  intake_t       state, state_nxt;
  logic          capture;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] q_cnt, cnt_nxt;
  logic          full, overflow, uart_clr;

  logic          is_flush_cmd, flush, pop, push, drop;

  // --------------------------------------------------------------------------
  // Intake FSM: TAKE captures on uart_rdy, RELEASE waits for the wrapper to
  // drop ready so a slow-falling flag is never captured twice.
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= TAKE;
    else     state <= state_nxt;
  end

  // NOTE: next-state starts from a default so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      TAKE:    if (bus.uart_rdy)  state_nxt = RELEASE;
      RELEASE: if (!bus.uart_rdy) state_nxt = TAKE;
      default: state_nxt = TAKE;
    endcase
  end

  always_comb begin
    capture = (state == TAKE) && bus.uart_rdy;
  end

  // --------------------------------------------------------------------------
  // Capture classification and queue control. Flush outranks push/pop; a
  // pop at full frees the slot the simultaneous push needs.
  // --------------------------------------------------------------------------
  always_comb begin
    is_flush_cmd = capture && (bus.uart_cmd == FLUSH_CMD);
    flush        = bus.bmp_flush || is_flush_cmd;
    pop          = bus.clr_cmd_rdy && (q_cnt != '0) && !flush;
    push         = capture && !is_flush_cmd && (!full || pop) && !flush;
    drop         = capture && !is_flush_cmd && full && !pop && !flush;

    cnt_nxt = q_cnt;
    if (flush)             cnt_nxt = '0;
    else if (push && !pop) cnt_nxt = q_cnt + CW'(1);
    else if (pop && !push) cnt_nxt = q_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_cnt    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      uart_clr <= 1'b0;
    end else begin
      uart_clr <= capture;
      q_cnt    <= cnt_nxt;
      full     <= (cnt_nxt == DEPTH_C);
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (pop)  rd_ptr   <= rd_ptr + AW'(1);
        if (push) wr_ptr   <= wr_ptr + AW'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // NOTE: queue storage has no reset; stale entries are never visible because
  // cmd_rdy is gated by q_cnt, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.uart_cmd;
  end

  // --------------------------------------------------------------------------
  // Outputs: cmd/cmd_rdy decode registers only; the rest are registers.
  // --------------------------------------------------------------------------
  assign bus.cmd      = mem[rd_ptr];
  assign bus.cmd_rdy  = (q_cnt != '0);
  assign bus.q_cnt    = q_cnt;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.uart_clr = uart_clr;

endmodule

// File: tb/tb_cmd_queue_sched.sv
// ----------------------------------------------------------------------------
// tb_cmd_queue_sched
// Directed bench for cmd_queue_sched (DEPTH=4, FLUSH_CMD=16'h0000). Inputs
// change 1 ns after the rising edge; outputs are sampled there too, so every
// check sees the state produced by the preceding edge.
// ----------------------------------------------------------------------------
module tb_cmd_queue_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  cmd_queue_sched_if #(.DEPTH(4)) bus ();

  cmd_queue_sched #(.DEPTH(4), .FLUSH_CMD(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full intake handshake: capture cycle, then release cycle.
  task automatic send(input logic [15:0] val);
    bus.uart_cmd = val;
    bus.uart_rdy = 1'b1;
    tick();
    check("send_clr_hi", 32'(bus.uart_clr), 32'd1);
    bus.uart_rdy = 1'b0;
    tick();
    check("send_clr_lo", 32'(bus.uart_clr), 32'd0);
  endtask

  task automatic pop_expect(input logic [15:0] exp);
    check("pop_cmd", 32'(bus.cmd), 32'(exp));
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  int clr_pulses;

  initial begin
    bus.uart_cmd    = 16'h0;
    bus.uart_rdy    = 1'b0;
    bus.bmp_flush   = 1'b0;
    bus.clr_cmd_rdy = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_q_cnt",    32'(bus.q_cnt),    32'd0);
    check("rst_cmd_rdy",  32'(bus.cmd_rdy),  32'd0);
    check("rst_uart_clr", 32'(bus.uart_clr), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_full",     32'(bus.full),     32'd0);

    // Single command: visible the cycle after capture
    bus.uart_cmd = 16'h0003;
    bus.uart_rdy = 1'b1;
    tick();
    check("single_clr",     32'(bus.uart_clr), 32'd1);
    check("single_cmd_rdy", 32'(bus.cmd_rdy),  32'd1);
    check("single_cmd",     32'(bus.cmd),      32'h0003);
    check("single_q_cnt",   32'(bus.q_cnt),    32'd1);
    bus.uart_rdy = 1'b0;
    tick();
    check("single_clr_1cyc", 32'(bus.uart_clr), 32'd0);
    pop_expect(16'h0003);
    check("single_pop_cnt", 32'(bus.q_cnt),   32'd0);
    check("single_pop_rdy", 32'(bus.cmd_rdy), 32'd0);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) send(16'(i));
    check("fill_full",  32'(bus.full),     32'd1);
    check("fill_cnt",   32'(bus.q_cnt),    32'd4);
    check("fill_ovf0",  32'(bus.overflow), 32'd0);
    send(16'h0005);
    check("ovf_set",    32'(bus.overflow), 32'd1);
    check("ovf_cnt",    32'(bus.q_cnt),    32'd4);
    for (int i = 1; i <= 4; i++) pop_expect(16'(i));
    check("ovf_drain_cnt", 32'(bus.q_cnt),    32'd0);
    check("ovf_sticky",    32'(bus.overflow), 32'd1);

    // Clear overflow with a bump flush before the push+pop-at-full case
    bus.bmp_flush = 1'b1;
    tick();
    bus.bmp_flush = 1'b0;
    check("pre_flush_ovf", 32'(bus.overflow), 32'd0);

    // Push + pop at full
    for (int i = 0; i < 4; i++) send(16'h0021 + 16'(i));
    check("pp_full", 32'(bus.full), 32'd1);
    check("pp_head", 32'(bus.cmd),  32'h0021);
    bus.uart_cmd    = 16'h00AA;
    bus.uart_rdy    = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    bus.uart_rdy    = 1'b0;
    check("pp_cnt",  32'(bus.q_cnt),    32'd4);
    check("pp_ovf",  32'(bus.overflow), 32'd0);
    check("pp_clr",  32'(bus.uart_clr), 32'd1);
    tick();
    pop_expect(16'h0022);
    pop_expect(16'h0023);
    pop_expect(16'h0024);
    pop_expect(16'h00AA);
    check("pp_empty", 32'(bus.cmd_rdy), 32'd0);

    // Wrap-around: overlapped push of the next value with pop of the current
    send(16'h0010);
    for (int i = 1; i < 10; i++) begin
      check("wrap_cmd", 32'(bus.cmd), 32'h0010 + 32'(i - 1));
      bus.uart_cmd    = 16'h0010 + 16'(i);
      bus.uart_rdy    = 1'b1;
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.uart_rdy    = 1'b0;
      bus.clr_cmd_rdy = 1'b0;
      check("wrap_cnt", 32'(bus.q_cnt), 32'd1);
      tick();
    end
    pop_expect(16'h0019);
    check("wrap_empty", 32'(bus.q_cnt), 32'd0);

    // Bump flush: 3 entries plus overflow
    for (int i = 1; i <= 5; i++) send(16'h0030 + 16'(i));
    pop_expect(16'h0031);
    check("bf_pre_cnt", 32'(bus.q_cnt),    32'd3);
    check("bf_pre_ovf", 32'(bus.overflow), 32'd1);
    bus.bmp_flush = 1'b1;
    tick();
    bus.bmp_flush = 1'b0;
    check("bf_cnt", 32'(bus.q_cnt),    32'd0);
    check("bf_rdy", 32'(bus.cmd_rdy),  32'd0);
    check("bf_ovf", 32'(bus.overflow), 32'd0);

    // Host flush via FLUSH_CMD
    for (int i = 1; i <= 5; i++) send(16'h0040 + 16'(i));
    pop_expect(16'h0041);
    check("hf_pre_cnt", 32'(bus.q_cnt), 32'd3);
    send(16'h0000);
    check("hf_cnt", 32'(bus.q_cnt),    32'd0);
    check("hf_rdy", 32'(bus.cmd_rdy),  32'd0);
    check("hf_ovf", 32'(bus.overflow), 32'd0);

    // Pop on empty is ignored; next push lands cleanly at the head
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    check("underflow_cnt", 32'(bus.q_cnt), 32'd0);
    send(16'h0055);
    check("after_flush_cmd", 32'(bus.cmd),   32'h0055);
    check("after_flush_cnt", 32'(bus.q_cnt), 32'd1);

    // Held uart_rdy: exactly one capture and one uart_clr pulse
    clr_pulses   = 0;
    bus.uart_cmd = 16'h0077;
    bus.uart_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.uart_clr) clr_pulses++;
    end
    check("held_pulses", 32'(clr_pulses), 32'd1);
    check("held_cnt",    32'(bus.q_cnt),  32'd2);

    // Reset during RELEASE with 2 entries queued, uart_rdy still high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cnt", 32'(bus.q_cnt),    32'd0);
    check("midrst_clr", 32'(bus.uart_clr), 32'd0);
    check("midrst_rdy", 32'(bus.cmd_rdy),  32'd0);
    // FSM back in TAKE: the still-high uart_rdy is captured on the next edge
    tick();
    check("midrst_take_clr", 32'(bus.uart_clr), 32'd1);
    check("midrst_take_cnt", 32'(bus.q_cnt),    32'd1);
    check("midrst_take_cmd", 32'(bus.cmd),      32'h0077);
    bus.uart_rdy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
